// File: rtl/recomb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : recomb_pkg
// Description : Shared constants for the radix-4 recombiner: FSM state
//               encoding, default operand width and radix-4 digit values.
// Revision    : 1.0 - initial release
// ============================================================================
package recomb_pkg;

  // FSM state encoding
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ITER  = 2'b01;
  localparam logic [1:0] S_FINAL = 2'b10;

  // Default operand width (must be even and >= 4)
  localparam int DEFAULT_WIDTH = 8;

  // Radix-4 digit values, same digit set the SRT divider emits
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

endpackage : recomb_pkg
`default_nettype wire

// File: rtl/digit_multiple.sv
`default_nettype none
// ============================================================================
// Module      : digit_multiple
// Description : Combinational radix-4 digit multiple: m = d * b, d in 0..3.
//               3b is built as (b<<1)+b so no real multiplier is needed.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_multiple
  import recomb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       d,
  output logic [WIDTH+1:0] m
);

  logic [WIDTH+1:0] b1;
  logic [WIDTH+1:0] b2;

  assign b1 = {2'b00, b};
  assign b2 = {1'b0, b, 1'b0};

  // Select the digit multiple; all results fit in WIDTH+2 bits
  always_comb begin
    m = '0;
    case (d)
      Q0:      m = '0;
      Q1:      m = b1;
      Q2:      m = b2;
      Q3:      m = b2 + b1;
      default: m = '0;
    endcase
  end

endmodule : digit_multiple
`default_nettype wire

// File: rtl/radix4_recombiner.sv
`default_nettype none
// ============================================================================
// Module      : radix4_recombiner
// Description : Sequential radix-4 multiply-add p = a*b + c, consuming the
//               multiplier two bits per cycle, MSB digit first. Inverse
//               datapath of the SRT divider (quotient->a, divisor->b,
//               remainder->c).
//               Optional macro RECOMBINER_CHECK_EN adds n_ref / check_ok,
//               flagging a correct quotient/remainder pair.
// Revision    : 1.0 - initial release
// ============================================================================
module radix4_recombiner
  import recomb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
`ifdef RECOMBINER_CHECK_EN
  input  logic [WIDTH-1:0]   n_ref,
  output logic               check_ok,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q,  a_sh_d;
  logic [WIDTH-1:0]   b_q,     b_d;
  logic [WIDTH-1:0]   c_q,     c_d;
  logic [2*WIDTH-1:0] acc_q,   acc_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic [2*WIDTH-1:0] p_q,     p_d;
  logic [WIDTH+1:0]   mult;
  logic [2*WIDTH-1:0] sum;

  digit_multiple #(.WIDTH(WIDTH)) u_digit_multiple (
    .b (b_q),
    .d (a_sh_q[WIDTH-1:WIDTH-2]),
    .m (mult)
  );

  // Final sum; c_r is zero-extended, no overflow is possible
  assign sum = acc_q + {{WIDTH{1'b0}}, c_q};

`ifdef RECOMBINER_CHECK_EN
  logic [WIDTH-1:0] n_q, n_d;
  logic             check_ok_q, check_ok_d;
`endif

  // Next-state and datapath logic for IDLE / ITER / FINAL
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    p_d     = p_q;
`ifdef RECOMBINER_CHECK_EN
    n_d        = n_q;
    check_ok_d = check_ok_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_d     = b;
          c_d     = c;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ITER;
`ifdef RECOMBINER_CHECK_EN
          n_d     = n_ref;
`endif
        end
      end
      S_ITER: begin
        acc_d  = {acc_q[2*WIDTH-3:0], 2'b00} + {{(WIDTH-2){1'b0}}, mult};
        a_sh_d = {a_sh_q[WIDTH-3:0], 2'b00};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        p_d     = sum;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
`ifdef RECOMBINER_CHECK_EN
        check_ok_d = (sum == {{WIDTH{1'b0}}, n_q}) && (c_q < b_q) && (b_q != '0);
`endif
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
`ifdef RECOMBINER_CHECK_EN
      n_q        <= '0;
      check_ok_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_q     <= b_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      p_q     <= p_d;
`ifdef RECOMBINER_CHECK_EN
      n_q        <= n_d;
      check_ok_q <= check_ok_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;
`ifdef RECOMBINER_CHECK_EN
  assign check_ok = check_ok_q;
`endif

endmodule : radix4_recombiner
`default_nettype wire

// File: tb/tb_radix4_recombiner.sv
`default_nettype none
// ============================================================================
// Module      : tb_radix4_recombiner
// Description : Self-checking bench for radix4_recombiner. Expected results
//               come from plain integer arithmetic (a*b+c) and a cycle-count
//               model of the accept/done protocol.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_radix4_recombiner;

  localparam int W   = 8;
  localparam int DIG = W / 2;

  logic           clk = 1'b0;
  logic           resetn;
  logic           start;
  logic [W-1:0]   a, b, c;
  logic           busy, done;
  logic [2*W-1:0] p;
`ifdef RECOMBINER_CHECK_EN
  logic [W-1:0]   n_ref;
  logic           check_ok;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  radix4_recombiner #(.WIDTH(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .a        (a),
    .b        (b),
    .c        (c),
`ifdef RECOMBINER_CHECK_EN
    .n_ref    (n_ref),
    .check_ok (check_ok),
`endif
    .busy     (busy),
    .done     (done),
    .p        (p)
  );

  // Reference: unsigned multiply-add
  function automatic logic [2*W-1:0] ref_mac(input logic [W-1:0] x, y, z);
    int unsigned r;
    r = int'(x) * int'(y) + int'(z);
    return r[2*W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accept edge, then drop start
  task automatic launch(input logic [W-1:0] x, y, z, input logic [W-1:0] n);
    a = x; b = y; c = z; start = 1'b1;
`ifdef RECOMBINER_CHECK_EN
    n_ref = n;
`else
    if (n != n) $display("unreachable");
`endif
    step();
    start = 1'b0;
  endtask

  // Wait (bounded) for done; returns cycles since accept, -1 on timeout
  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      if (done === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; a = '0; b = '0; c = '0;
`ifdef RECOMBINER_CHECK_EN
    n_ref = '0;
`endif
    step(); step();
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (p !== '0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d: p=%h busy=%b done=%b, required p=0 busy=0 done=0",
                 i, p, busy, done);
      end
`ifdef RECOMBINER_CHECK_EN
      vectors++;
      if (check_ok !== 1'b0) begin
        errors++;
        $display("FAIL reset_check_ok: got %b, required 0", check_ok);
      end
`endif
      step();
    end
  endtask

  task automatic test_basic();
    launch(8'h1A, 8'h09, 8'h04, 8'd238);
    for (int i = 0; i < DIG + 1; i++) begin
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL basic_busy cyc=%0d: busy=%b done=%b, required busy=1 done=0", i, busy, done);
      end
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      step();
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || p !== 16'h00EE) begin
      errors++;
      $display("FAIL basic_result: done=%b busy=%b p=%h, required done=1 busy=0 p=00ee", done, busy, p);
    end
    step();
    vectors++;
    if (done !== 1'b0 || p !== 16'h00EE) begin
      errors++;
      $display("FAIL basic_hold: done=%b p=%h, required done=0 p=00ee", done, p);
    end
  endtask

  task automatic test_corners();
    int cyc;
    launch(8'hFF, 8'hFF, 8'hFF, 8'h00);
    wait_done(cyc);
    vectors++;
    if (cyc !== DIG + 1 || p !== 16'hFF00) begin
      errors++;
      $display("FAIL max_operands: latency=%0d p=%h, required latency=%0d p=ff00", cyc, p, DIG + 1);
    end
    step();
    launch(8'h00, 8'hFF, 8'h07, 8'h07);
    wait_done(cyc);
    vectors++;
    if (cyc !== DIG + 1 || p !== 16'h0007) begin
      errors++;
      $display("FAIL zero_multiplier: latency=%0d p=%h, required latency=%0d p=0007", cyc, p, DIG + 1);
    end
    step();
  endtask

  task automatic test_random();
    int cyc;
    logic [W-1:0] x, y, z;
    for (int k = 0; k < 20; k++) begin
      x = W'($urandom); y = W'($urandom); z = W'($urandom);
      launch(x, y, z, W'($urandom));
      wait_done(cyc);
      vectors++;
      if (cyc !== DIG + 1 || p !== ref_mac(x, y, z)) begin
        errors++;
        $display("FAIL random_op %0d: a=%h b=%h c=%h latency=%0d p=%h, required latency=%0d p=%h",
                 k, x, y, z, cyc, p, DIG + 1, ref_mac(x, y, z));
      end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
    end
  endtask

  // start held high with operands changing every cycle
  task automatic test_back_to_back();
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] e;
    int  rem = 0;
    bit  exp_done;
    start = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 30) start = 1'b0;
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      exp_done = 1'b0;
      if (rem == 0) begin
        if (start) begin
          exp_q.push_back(ref_mac(a, b, c));
          rem = DIG + 1;
        end
      end else begin
        rem--;
        if (rem == 0) exp_done = 1'b1;
      end
      step();
      vectors++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL b2b_done cyc=%0d: done=%b, required %b", cyc, done, exp_done);
      end
      if (done === 1'b1 && exp_done) begin
        e = exp_q.pop_front();
        vectors++;
        if (p !== e) begin
          errors++;
          $display("FAIL b2b_result cyc=%0d: p=%h, required %h", cyc, p, e);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    launch(8'hC3, 8'h5A, 8'h11, 8'h00);
    step(); step();            // two ITER edges done; next edge is 3rd ITER
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    vectors++;
    if (p !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: p=%h busy=%b done=%b, required p=0 busy=0 done=0", p, busy, done);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midop_no_done cyc=%0d: done=%b busy=%b, required 0 0", i, done, busy);
      end
    end
    launch(8'h37, 8'h2B, 8'h0E, 8'h00);
    wait_done(cyc);
    vectors++;
    if (cyc !== DIG + 1 || p !== ref_mac(8'h37, 8'h2B, 8'h0E)) begin
      errors++;
      $display("FAIL midop_fresh: latency=%0d p=%h, required latency=%0d p=%h",
               cyc, p, DIG + 1, ref_mac(8'h37, 8'h2B, 8'h0E));
    end
    step();
  endtask

`ifdef RECOMBINER_CHECK_EN
  task automatic test_check();
    int cyc;
    logic [W-1:0] x [7];
    logic [W-1:0] y [7];
    logic [W-1:0] z [7];
    logic [W-1:0] n [7];
    logic         e;
    x[0] = 8'd26; y[0] = 8'd9; z[0] = 8'd4; n[0] = 8'd238;
    x[1] = 8'd26; y[1] = 8'd9; z[1] = 8'd4; n[1] = 8'd239;
    x[2] = 8'd26; y[2] = 8'd9; z[2] = 8'd9; n[2] = 8'd243;
    for (int k = 3; k < 7; k++) begin
      y[k] = W'($urandom_range(1, 255));
      n[k] = W'($urandom);
      x[k] = n[k] / y[k];
      z[k] = n[k] % y[k];
    end
    for (int k = 0; k < 7; k++) begin
      e = (int'(x[k]) * int'(y[k]) + int'(z[k]) == int'(n[k])) && (z[k] < y[k]) && (y[k] != 0);
      launch(x[k], y[k], z[k], n[k]);
      wait_done(cyc);
      vectors++;
      if (check_ok !== e || p !== ref_mac(x[k], y[k], z[k])) begin
        errors++;
        $display("FAIL check_ok case %0d: check_ok=%b p=%h, required check_ok=%b p=%h",
                 k, check_ok, p, e, ref_mac(x[k], y[k], z[k]));
      end
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
`ifdef RECOMBINER_CHECK_EN
    test_check();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_radix4_recombiner
`default_nettype wire
